uart_avalon_host: RTL and testbench
===================================

// Module: uart_avalon_host
// PURPOSE
//  Avalon-MM master that drives the UART Avalon slave register map on behalf of local logic.
//  Accepts bytes on a valid/ready stream and writes them into the slave's TX FIFO.
//  Polls the slave status register and drains received bytes onto an rx stream.
//  Sits between a local controller (e.g. a command parser) and the memory-mapped UART.
// PARAMETERS
//  P         0   parity bit present in slave data_rx (rx_data width = 8+P)
//  POLL_GAP  16  idle cycles between status polls (>=1)
// PORTS
//  clk         in   1     system clock, all logic on posedge
//  reset       in   1     synchronous, active-high
//  address     out  2     slave register: 0 data_tx, 1 data_rx, 2 status, 3 control
//  chipselect  out  1     high on every read/write cycle
//  read        out  1     1-cycle read strobe
//  write       out  1     1-cycle write strobe
//  writedata   out  32    write payload
//  readdata    in   32    slave read data, valid exactly 1 cycle after read strobe
//  tx_data     in   8     byte to transmit
//  tx_valid    in   1     tx_data valid
//  tx_ready    out  1     1-cycle pulse: tx_data accepted this cycle
//  rx_data     out  8+P   received byte ([8] = parity bit when P=1)
//  rx_valid    out  1     1-cycle pulse: rx_data valid
//  busy        out  1     high in any state other than IDLE
// BEHAVIOUR
//  Reset (sync, high): all outputs 0, FSM -> IDLE, poll counter cleared. Reset mid-transaction aborts it; no strobe after.
//  Bus: at most one of read/write per cycle; each strobe lasts 1 cycle; address/writedata valid only with strobe, else 0.
//  Read latency fixed at 1: readdata sampled in the cycle after read; no waitrequest.
//  Status bits: [0] full_tx [1] empty_tx [2] full_rx [3] empty_rx [4] tx_tick [5] rx_tick.
//  Control bits: [0] wr [1] start [2] rd. Slave acts on rising edge, so every pulse = write 1 then write 0.
//  FSM:
//   IDLE     count POLL_GAP cycles (or immediately if tx_valid) -> ST_RD
//   ST_RD    read addr 2 -> ST_WAIT;  ST_WAIT  latch status -> DECIDE
//   DECIDE   !empty_rx -> RX_RD; else tx_valid && !full_tx -> TX_WR; else IDLE (RX has priority)
//   RX_RD    read addr 1 -> RX_WAIT;  RX_WAIT  rx_data<=readdata[7+P:0], rx_valid=1 -> RX_P1
//   RX_P1    write ctl=32'h4 -> RX_P0;  RX_P0  write ctl=0 -> IDLE (head read before pop)
//   TX_WR    write addr 0 = {24'b0,tx_data}, tx_ready=1 -> TX_W1
//   TX_W1    write ctl=32'h1 -> TX_W0;  TX_W0  write ctl=0 -> TX_S1
//   TX_S1    write ctl=32'h2 -> TX_S0;  TX_S0  write ctl=0 -> IDLE
//  tx_data sampled only in TX_WR; tx_valid drop before TX_WR -> no transfer, no tx_ready.
//  full_tx=1: byte held, tx_ready stays 0, repoll after POLL_GAP. empty_rx=1: no rx read.
//  Poll counter wraps to 0 on reaching POLL_GAP-1; cleared on leaving IDLE.
//  Simultaneous rx pending + tx_valid: full RX sequence first, TX on the next poll.
//  Latency: tx byte accepted 4 cycles after IDLE exit (ST_RD,ST_WAIT,DECIDE,TX_WR); rx_valid 5 cycles after.
// TESTING
//  1 status=0x0A (empty_tx,empty_rx), tx_valid, tx_data=0x55 -> write a0 0x55, ctl 1,0,2,0; one tx_ready
//  2 status=0x02 (rx not empty), data_rx=0x3C -> read a1, rx_data=0x3C + 1 rx_valid, ctl 4,0; no TX
//  3 status full_tx=1 with tx_valid held -> only status reads every POLL_GAP+3 cycles, tx_ready=0
//  4 rx pending and tx_valid both -> RX sequence completes before data_tx write; order checked
//  5 reset asserted in TX_W1 -> next cycle write=read=0, busy=0, outputs 0; restarts clean
//  6 P=1, data_rx=0x1A5 -> rx_data=9'h1A5; loop back via uart_avalon model, 4 bytes round-trip intact

Source files
------------

// File: rtl/uart_avalon_host_if.sv
// Avalon-MM bus between the UART host (master) and the UART register slave.
interface uart_avalon_host_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (output address, chipselect, read, write, writedata, input readdata);
  modport slave  (input address, chipselect, read, write, writedata, output readdata);
endinterface

// File: rtl/uart_avalon_host.sv
// Avalon-MM master that polls the UART slave status register, pushes stream
// bytes into its TX FIFO and drains received bytes onto an rx stream.
module uart_avalon_host #(
  parameter int P        = 0,
  parameter int POLL_GAP = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  uart_avalon_host_if.master   bus,
  input  logic [7:0]           tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic [7+P:0]         rx_data,
  output logic                 rx_valid,
  output logic                 busy
);
  localparam int CW = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
  localparam logic [CW-1:0] LAST = CW'(POLL_GAP - 1);

  localparam logic [1:0] A_TX = 2'd0, A_RX = 2'd1, A_ST = 2'd2, A_CTL = 2'd3;

  typedef enum logic [3:0] {
    IDLE, ST_RD, ST_WAIT, DECIDE,
    RX_RD, RX_WAIT, RX_P1, RX_P0,
    TX_WR, TX_W1, TX_W0, TX_S1, TX_S0
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          hold;       // tx was blocked by full_tx: ignore tx_valid until next timed poll
  logic          full_tx;
  logic          empty_rx;
  logic [1:0]    address;
  logic          chipselect, read, write;
  logic [31:0]   writedata;

  assign bus.address    = address;
  assign bus.chipselect = chipselect;
  assign bus.read       = read;
  assign bus.write      = write;
  assign bus.writedata  = writedata;
  assign busy           = (state != IDLE);

  // Upper readdata bits carry nothing this master needs.
  logic unused_rd;
  assign unused_rd = ^bus.readdata[31:8+P];

  // Control FSM; every bus output is registered and set on entry to the state
  // that owns the strobe, so strobes last exactly one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      hold       <= 1'b0;
      full_tx    <= 1'b0;
      empty_rx   <= 1'b0;
      address    <= '0;
      chipselect <= 1'b0;
      read       <= 1'b0;
      write      <= 1'b0;
      writedata  <= '0;
      tx_ready   <= 1'b0;
      rx_valid   <= 1'b0;
      rx_data    <= '0;
    end else begin
      address    <= '0;
      chipselect <= 1'b0;
      read       <= 1'b0;
      write      <= 1'b0;
      writedata  <= '0;
      tx_ready   <= 1'b0;
      rx_valid   <= 1'b0;
      case (state)
        IDLE: begin
          if ((tx_valid && !hold) || cnt == LAST) begin
            state      <= ST_RD;
            cnt        <= '0;
            hold       <= 1'b0;
            read       <= 1'b1;
            chipselect <= 1'b1;
            address    <= A_ST;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_RD:   state <= ST_WAIT;
        ST_WAIT: begin
          full_tx  <= bus.readdata[0];
          empty_rx <= bus.readdata[3];
          state    <= DECIDE;
        end
        DECIDE: begin
          if (!empty_rx) begin
            state      <= RX_RD;
            read       <= 1'b1;
            chipselect <= 1'b1;
            address    <= A_RX;
          end else if (tx_valid && !full_tx) begin
            state      <= TX_WR;
            write      <= 1'b1;
            chipselect <= 1'b1;
            address    <= A_TX;
            writedata  <= {24'b0, tx_data};
            tx_ready   <= 1'b1;
          end else begin
            state <= IDLE;
            hold  <= tx_valid;
          end
        end
        RX_RD:   state <= RX_WAIT;
        RX_WAIT: begin
          // head byte is captured before the rd pulse pops it
          rx_data    <= bus.readdata[7+P:0];
          rx_valid   <= 1'b1;
          state      <= RX_P1;
          write      <= 1'b1;
          chipselect <= 1'b1;
          address    <= A_CTL;
          writedata  <= 32'h4;
        end
        RX_P1: begin
          state      <= RX_P0;
          write      <= 1'b1;
          chipselect <= 1'b1;
          address    <= A_CTL;
        end
        RX_P0:   state <= IDLE;
        TX_WR: begin
          state      <= TX_W1;
          write      <= 1'b1;
          chipselect <= 1'b1;
          address    <= A_CTL;
          writedata  <= 32'h1;
        end
        TX_W1: begin
          state      <= TX_W0;
          write      <= 1'b1;
          chipselect <= 1'b1;
          address    <= A_CTL;
        end
        TX_W0: begin
          state      <= TX_S1;
          write      <= 1'b1;
          chipselect <= 1'b1;
          address    <= A_CTL;
          writedata  <= 32'h2;
        end
        TX_S1: begin
          state      <= TX_S0;
          write      <= 1'b1;
          chipselect <= 1'b1;
          address    <= A_CTL;
        end
        TX_S0:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_avalon_host.sv
// Scoreboard bench: dut0 (P=0) against a scripted register slave, dut1 (P=1)
// against a loopback UART slave model.
module tb_uart_avalon_host;
  localparam int PG = 4;
  localparam logic [1:0] KR = 2'd0, KW = 2'd1, KT = 2'd2, KV = 2'd3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [7:0] tx_data0, tx_data1, rx_data0;
  logic [8:0] rx_data1;
  logic       tx_valid0, tx_valid1, tx_ready0, tx_ready1;
  logic       rx_valid0, rx_valid1, busy0, busy1;

  uart_avalon_host_if bus0();
  uart_avalon_host_if bus1();

  uart_avalon_host #(.P(0), .POLL_GAP(PG)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0), .tx_data(tx_data0), .tx_valid(tx_valid0),
    .tx_ready(tx_ready0), .rx_data(rx_data0), .rx_valid(rx_valid0), .busy(busy0));

  uart_avalon_host #(.P(1), .POLL_GAP(PG)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1), .tx_data(tx_data1), .tx_valid(tx_valid1),
    .tx_ready(tx_ready1), .rx_data(rx_data1), .rx_valid(rx_valid1), .busy(busy1));

  typedef struct packed {
    logic [1:0]  kind;
    logic [1:0]  addr;
    logic [31:0] data;
  } ev_t;

  ev_t        q0[$];
  logic [8:0] q1[$];
  int checks = 0, errors = 0;
  int cyc = 0, last_poll = 0, npoll0 = 0;
  bit chk_gap = 0, have_prev = 0;

  // scripted slave state for dut0
  logic [31:0] st0, drx0;

  function automatic void ex(input logic [1:0] k, input logic [1:0] a, input logic [31:0] d);
    ev_t e;
    e.kind = k; e.addr = a; e.data = d;
    q0.push_back(e);
  endfunction

  function automatic void push_tx(input logic [7:0] b);
    ex(KW, 2'd0, {24'b0, b});
    ex(KT, 2'd0, {24'b0, b});
    ex(KW, 2'd3, 32'h1);
    ex(KW, 2'd3, 32'h0);
    ex(KW, 2'd3, 32'h2);
    ex(KW, 2'd3, 32'h0);
  endfunction

  task automatic check_ev(input ev_t got);
    ev_t exp;
    checks++;
    if (q0.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event: got kind=%0d addr=%0d data=%h, required none", got.kind, got.addr, got.data);
    end else begin
      exp = q0.pop_front();
      if (got !== exp) begin
        errors++;
        $display("FAIL bus_event: got kind=%0d addr=%0d data=%h, required kind=%0d addr=%0d data=%h",
                 got.kind, got.addr, got.data, exp.kind, exp.addr, exp.data);
      end
    end
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, got, exp);
    end
  endtask

  // Scripted slave: status/data_rx from bench variables, 1-cycle read latency,
  // rd rising edge marks the RX FIFO empty.
  initial begin : slave0
    logic        pend;
    logic [31:0] val;
    logic [2:0]  ctl;
    pend = 0; val = 0; ctl = 0;
    bus0.readdata = 0;
    forever begin
      @(posedge clk); #1;
      bus0.readdata = pend ? val : 32'h0;
      pend = 0;
      if (bus0.read) begin
        pend = 1;
        val  = (bus0.address == 2'd2) ? st0 : (bus0.address == 2'd1) ? drx0 : 32'h0;
      end
      if (bus0.write && bus0.address == 2'd3) begin
        if (bus0.writedata[2] && !ctl[2]) st0 = st0 | 32'h8;
        ctl = bus0.writedata[2:0];
      end
    end
  end

  // Loopback UART slave: start moves the TX FIFO head into the RX FIFO with odd parity.
  initial begin : slave1
    logic        pend;
    logic [31:0] val;
    logic [2:0]  ctl;
    logic [7:0]  dtx, b;
    logic [7:0]  txq[$];
    logic [8:0]  rxq[$];
    pend = 0; val = 0; ctl = 0; dtx = 0;
    bus1.readdata = 0;
    forever begin
      @(posedge clk); #1;
      bus1.readdata = pend ? val : 32'h0;
      pend = 0;
      if (bus1.read) begin
        pend = 1;
        case (bus1.address)
          2'd1:    val = (rxq.size() != 0) ? {23'b0, rxq[0]} : 32'h0;
          2'd2:    val = {28'b0, rxq.size() == 0, rxq.size() >= 4, txq.size() == 0, txq.size() >= 4};
          default: val = 32'h0;
        endcase
      end
      if (bus1.write && bus1.address == 2'd0) dtx = bus1.writedata[7:0];
      if (bus1.write && bus1.address == 2'd3) begin
        if (bus1.writedata[0] && !ctl[0]) txq.push_back(dtx);
        if (bus1.writedata[1] && !ctl[1] && txq.size() != 0) begin
          b = txq.pop_front();
          rxq.push_back({~^b, b});
        end
        if (bus1.writedata[2] && !ctl[2] && rxq.size() != 0) void'(rxq.pop_front());
        ctl = bus1.writedata[2:0];
      end
    end
  end

  // Monitor for dut0: bus protocol, poll spacing, and scoreboard pops.
  initial begin : mon0
    ev_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (!reset) begin
        checks++;
        if ((bus0.read && bus0.write) || (bus0.chipselect != (bus0.read | bus0.write)) ||
            (!(bus0.read | bus0.write) && (bus0.address != 0 || bus0.writedata != 0))) begin
          errors++;
          $display("FAIL bus_protocol: rd=%b wr=%b cs=%b addr=%0d wdata=%h, required one strobe and idle fields 0",
                   bus0.read, bus0.write, bus0.chipselect, bus0.address, bus0.writedata);
        end
        if (bus0.read && bus0.address == 2'd2) begin
          if (chk_gap && have_prev) begin
            checks++;
            if (cyc - last_poll != PG + 3) begin
              errors++;
              $display("FAIL poll_gap: got %0d cycles, required %0d", cyc - last_poll, PG + 3);
            end
          end
          last_poll = cyc;
          have_prev = 1;
          npoll0++;
        end else if (bus0.read || bus0.write) begin
          e.kind = bus0.write ? KW : KR;
          e.addr = bus0.address;
          e.data = bus0.writedata;
          check_ev(e);
        end
        if (tx_ready0) begin
          e.kind = KT; e.addr = 2'd0; e.data = {24'b0, tx_data0};
          check_ev(e);
        end
        if (rx_valid0) begin
          e.kind = KV; e.addr = 2'd0; e.data = {24'b0, rx_data0};
          check_ev(e);
        end
      end
    end
  end

  // Monitor for dut1: received bytes against the loopback expectation.
  initial begin : mon1
    logic [8:0] exp;
    forever begin
      @(negedge clk);
      if (!reset && rx_valid1) begin
        checks++;
        if (q1.size() == 0) begin
          errors++;
          $display("FAIL rx1_unexpected: got %h, required none", rx_data1);
        end else begin
          exp = q1.pop_front();
          if (rx_data1 !== exp) begin
            errors++;
            $display("FAIL rx1_data: got %h, required %h", rx_data1, exp);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: time limit reached, required self-completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic wait_idle0();
    int n = 0;
    while (busy0 && n < 100) begin tick(); n++; end
    if (busy0) begin checks++; errors++; $display("FAIL idle0_timeout: busy=1, required 0"); end
  endtask

  task automatic wait_ready0();
    int n = 0;
    while (!tx_ready0 && n < 200) begin tick(); n++; end
    if (!tx_ready0) begin checks++; errors++; $display("FAIL tx_ready0_timeout: got 0, required 1"); end
    tx_valid0 = 0;
  endtask

  task automatic drain0();
    int n = 0;
    while (q0.size() != 0 && n < 300) begin tick(); n++; end
    if (q0.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain0_timeout: %0d events outstanding, required 0", q0.size());
      q0.delete();
    end
    wait_idle0();
  endtask

  task automatic wait_polls(input int k);
    int target = npoll0 + k;
    int n = 0;
    while (npoll0 < target && n < (PG + 3) * (k + 2) + 20) begin tick(); n++; end
    if (npoll0 < target) begin checks++; errors++; $display("FAIL poll_timeout: got %0d polls, required %0d", npoll0, target); end
  endtask

  task automatic send1(input logic [7:0] b);
    int n = 0;
    while (busy1 && n < 100) begin tick(); n++; end
    tx_data1 = b; tx_valid1 = 1;
    n = 0;
    while (!tx_ready1 && n < 200) begin tick(); n++; end
    if (!tx_ready1) begin checks++; errors++; $display("FAIL tx_ready1_timeout: got 0, required 1"); end
    tx_valid1 = 0;
  endtask

  logic [7:0] lb_in  [4] = '{8'hA5, 8'h00, 8'hFF, 8'h01};
  logic [8:0] lb_out [4] = '{9'h1A5, 9'h100, 9'h1FF, 9'h001};

  initial begin : stim
    reset = 1; tx_data0 = 0; tx_valid0 = 0; tx_data1 = 0; tx_valid1 = 0;
    st0 = 32'h0A; drx0 = 0;
    repeat (3) tick();
    chk("reset_out0", {bus0.read, bus0.write, bus0.chipselect, bus0.address, bus0.writedata,
                       tx_ready0, rx_valid0, busy0, rx_data0}, 64'h0);
    chk("reset_out1", {bus1.read, bus1.write, bus1.chipselect, bus1.address, bus1.writedata,
                       tx_ready1, rx_valid1, busy1, rx_data1}, 64'h0);
    reset = 0;

    // 1: plain TX
    wait_idle0();
    push_tx(8'h55);
    tx_data0 = 8'h55; tx_valid0 = 1;
    wait_ready0();
    drain0();

    // 2: RX only
    drx0 = 32'h3C;
    ex(KR, 2'd1, 32'h0); ex(KW, 2'd3, 32'h4); ex(KV, 2'd0, 32'h3C); ex(KW, 2'd3, 32'h0);
    st0 = 32'h02;
    drain0();

    // 3: TX blocked by full_tx, polls every PG+3 cycles, then released
    st0 = 32'h09; tx_data0 = 8'h5A; tx_valid0 = 1;
    wait_polls(2);
    have_prev = 0; chk_gap = 1;
    wait_polls(4);
    chk_gap = 0;
    push_tx(8'h5A);
    st0 = 32'h0A;
    wait_ready0();
    drain0();

    // 4: RX pending and TX valid together: RX runs to completion first
    drx0 = 32'h77;
    ex(KR, 2'd1, 32'h0); ex(KW, 2'd3, 32'h4); ex(KV, 2'd0, 32'h77); ex(KW, 2'd3, 32'h0);
    push_tx(8'h99);
    st0 = 32'h02; tx_data0 = 8'h99; tx_valid0 = 1;
    wait_ready0();
    drain0();

    // 5: reset during TX_W1 aborts the sequence
    ex(KW, 2'd0, 32'hC3); ex(KT, 2'd0, 32'hC3);
    tx_data0 = 8'hC3; tx_valid0 = 1;
    wait_ready0();
    tick();
    chk("tx_w1_strobe", {bus0.write, bus0.writedata}, {1'b1, 32'h1});
    reset = 1;
    tick();
    chk("abort_out", {bus0.read, bus0.write, bus0.chipselect, bus0.address, bus0.writedata,
                      tx_ready0, rx_valid0, busy0, rx_data0}, 64'h0);
    chk("abort_queue", 64'(q0.size()), 64'h0);
    tick();
    reset = 0;
    push_tx(8'h3E);
    tx_data0 = 8'h3E; tx_valid0 = 1;
    wait_ready0();
    drain0();

    // 6: P=1 loopback round-trip
    for (int i = 0; i < 4; i++) begin
      q1.push_back(lb_out[i]);
      send1(lb_in[i]);
    end
    begin
      int n = 0;
      while (q1.size() != 0 && n < 400) begin tick(); n++; end
      if (q1.size() != 0) begin
        checks++; errors++;
        $display("FAIL loopback_timeout: %0d bytes outstanding, required 0", q1.size());
      end
    end
    repeat (10) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
